uart_word_rx: RTL and testbench
===============================

UART_WORD_RX -- requirements
Module: uart_word_rx

Interface
REQ-001 Parameter WORD_BYTES, default 8: number of received bytes assembled into one output word.
REQ-002 Parameter TIMEOUT_CYCLES, default 1_000_000: idle clocks tolerated between bytes of a partial word.
REQ-003 clk  in  1  single clock for all logic; the UART receiver's rxclk is tied to the same clk.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 rx_empty  in  1  UART receiver status; 0 means a received byte is waiting.
REQ-006 rx_data  in  8  UART receiver holding register; valid one clock after uld_rx_data.
REQ-007 uld_rx_data  out  1  one-clock unload strobe to the UART receiver.
REQ-008 output_data  out  8*WORD_BYTES  assembled word.
REQ-009 output_valid  out  1  output_data is valid.
REQ-010 output_ready  in  1  consumer accepts the word.
REQ-011 timeout_err  out  1  one-clock pulse when a partial word is discarded.
REQ-012 byte_count  out  clog2(WORD_BYTES)+1  number of bytes held in the partial word, for status and debug.

Function
REQ-013 FSM states are S_IDLE, S_UNLOAD, S_CAPTURE and S_HOLD.
REQ-014 S_IDLE with rx_empty=0: assert uld_rx_data for exactly that one clock, then go to S_UNLOAD.
REQ-015 S_UNLOAD lasts one wait clock so that rx_data reflects the unloaded byte; uld_rx_data=0; then go to S_CAPTURE.
REQ-016 S_CAPTURE stores rx_data at byte lane byte_count (bits 8*i+7:8*i) and increments byte_count.
REQ-017 Byte order is little-endian: the first received byte lands in bits 7:0.
REQ-018 From S_CAPTURE, if the new byte_count equals WORD_BYTES, go to S_HOLD; otherwise go to S_IDLE.
REQ-019 S_HOLD: output_valid=1 and output_data is stable until output_ready=1.
REQ-020 The handshake completes on the clock where output_valid and output_ready are both 1; on the next clock output_valid=0, byte_count=0 and the state is S_IDLE.
REQ-021 output_valid does not depend combinationally on output_ready; output_ready is ignored outside S_HOLD.
REQ-022 In S_HOLD no byte is unloaded (uld_rx_data=0); backpressure propagates to the UART.
REQ-023 Minimum spacing is 3 clocks per byte, so word latency from the first rx_empty=0 is at least 3*WORD_BYTES clocks to output_valid.
REQ-024 Timeout counter: in S_IDLE with 0 < byte_count < WORD_BYTES and rx_empty=1, it increments every clock; it clears on every unload and whenever byte_count=0.
REQ-025 When the counter reaches TIMEOUT_CYCLES-1: discard the partial word (byte_count=0, data lanes 0), pulse timeout_err for one clock, and stay in S_IDLE.
REQ-026 If rx_empty=0 on the same clock the timeout fires, the timeout wins; the byte is unloaded on the following clock as the first byte of a new word.
REQ-027 The timeout counter does not run in S_HOLD or with byte_count=0.
REQ-028 Counter width is clog2(TIMEOUT_CYCLES)+1; the counter never wraps.

Reset
REQ-029 On rst=1 at a clock edge: state=S_IDLE, uld_rx_data=0, output_valid=0, output_data=0, timeout_err=0, byte_count=0, timeout counter=0.
REQ-030 rst asserted mid-word or in S_HOLD discards all held data with no output_valid pulse.
REQ-031 While rst=1, uld_rx_data stays 0.

Structure
REQ-032 State encoding localparams and the byte-lane width constant (8) reside in a shared include/package uart_pkg, also used by the transmit-side word serializer.
REQ-033 A single sub-module, uart_timeout_cnt (clear, enable, terminal-count pulse), is natural; everything else is flat.

Verification
REQ-034 Bench instantiates uart_word_rx with the existing UART, same clk, 16x oversampled serial stimulus.
REQ-035 Send bytes 0x01..0x08 with output_ready=1 -> one output_valid with output_data=64'h0807060504030201 and byte_count back to 0.
REQ-036 Send 8 bytes 0xA5 with output_ready=0 for 50 clocks -> output_valid held, data stable at 64'hA5A5A5A5A5A5A5A5, uld_rx_data=0 throughout; accepted on the clock output_ready rises.
REQ-037 TIMEOUT_CYCLES=100: send 3 bytes, then idle -> timeout_err pulses once, exactly 100 clocks after the last capture; the next 8 bytes 0x10..0x17 yield 64'h1716151413121110.
REQ-038 Assert rst after 5 bytes -> all outputs reach reset values next clock; a following 8-byte burst yields a correct word with no stale lanes.
REQ-039 Back-to-back words (16 bytes, output_ready=1) -> two output_valid pulses, each one clock long, with correct data and no byte lost or duplicated.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg : shared UART word-path state encoding and lane width   (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_UNLOAD  = 2'd1,
    S_CAPTURE = 2'd2,
    S_HOLD    = 2'd3
  } word_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_word_rx_if.sv
// ---------------------------------------------------------------------------
// uart_word_rx_if : UART holding-register side plus word handshake (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

interface uart_word_rx_if
  import uart_pkg::*;
#(
  parameter int WORD_BYTES = 8
) ();

  logic                           rx_empty;
  logic [BYTE_W-1:0]              rx_data;
  logic                           uld_rx_data;
  logic [BYTE_W*WORD_BYTES-1:0]   output_data;
  logic                           output_valid;
  logic                           output_ready;
  logic                           timeout_err;
  logic [$clog2(WORD_BYTES):0]    byte_count;

  modport master (
    input  rx_empty, rx_data, output_ready,
    output uld_rx_data, output_data, output_valid, timeout_err, byte_count
  );

  modport slave (
    output rx_empty, rx_data, output_ready,
    input  uld_rx_data, output_data, output_valid, timeout_err, byte_count
  );

endinterface

`default_nettype wire

// File: rtl/uart_timeout_cnt.sv
// ---------------------------------------------------------------------------
// uart_timeout_cnt : saturating idle counter with terminal-count flag (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module uart_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic clear,
  input  wire logic enable,
  output logic      tc
);

  localparam int            CW     = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  // Holds at the terminal value instead of wrapping; the owner clears it.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= '0;
    end else if (enable && (r_count != TC_VAL)) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign tc = (r_count == TC_VAL);

endmodule

`default_nettype wire

// File: rtl/uart_word_rx.sv
// ---------------------------------------------------------------------------
// uart_word_rx : packs UART bytes into little-endian words with timeout (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module uart_word_rx
  import uart_pkg::*;
#(
  parameter int WORD_BYTES     = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input wire logic        clk,
  input wire logic        rst,
  uart_word_rx_if.master  bus
);

  localparam int             BCW  = $clog2(WORD_BYTES) + 1;
  localparam logic [BCW-1:0] FULL = BCW'(WORD_BYTES);

  word_state_t                  r_state;
  word_state_t                  w_state_nxt;
  logic [BCW-1:0]               r_count;
  logic                         r_timeout_err;
  logic [BYTE_W*WORD_BYTES-1:0] w_data;
  logic                         w_uld;
  logic                         w_partial;
  logic                         w_tc;
  logic                         w_fire;
  logic                         w_capture;

  assign w_partial = (r_count != '0) && (r_count < FULL);
  assign w_fire    = (r_state == S_IDLE) && w_partial && w_tc;
  assign w_capture = (r_state == S_CAPTURE);

  uart_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_uld || (r_count == '0) || w_fire),
    .enable ((r_state == S_IDLE) && w_partial && bus.rx_empty),
    .tc     (w_tc)
  );

  // A firing timeout takes priority over a waiting byte; it is unloaded next clock.
  always_comb begin
    w_state_nxt = r_state;
    w_uld       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_fire && !bus.rx_empty) begin
          w_uld       = 1'b1;
          w_state_nxt = S_UNLOAD;
        end
      end
      S_UNLOAD:  w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = ((r_count + BCW'(1)) == FULL) ? S_HOLD : S_IDLE;
      S_HOLD: begin
        if (bus.output_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (rst) begin
      w_uld = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_count       <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_timeout_err <= w_fire;
      if (w_fire) begin
        r_count <= '0;
      end else if (w_capture) begin
        r_count <= r_count + BCW'(1);
      end else if ((r_state == S_HOLD) && bus.output_ready) begin
        r_count <= '0;
      end
    end
  end

  for (genvar i = 0; i < WORD_BYTES; i++) begin : g_lane
    logic [BYTE_W-1:0] r_lane;

    always_ff @(posedge clk) begin
      if (rst || w_fire) begin
        r_lane <= '0;
      end else if (w_capture && (r_count == BCW'(i))) begin
        r_lane <= bus.rx_data;
      end
    end

    assign w_data[BYTE_W*i +: BYTE_W] = r_lane;
  end

  assign bus.uld_rx_data  = w_uld;
  assign bus.output_data  = w_data;
  assign bus.output_valid = (r_state == S_HOLD);
  assign bus.timeout_err  = r_timeout_err;
  assign bus.byte_count   = r_count;

endmodule

`default_nettype wire

// File: tb/tb_uart_word_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_word_rx : scoreboard bench for uart_word_rx                (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_word_rx;

  localparam int WB  = 8;
  localparam int TMO = 100;

  logic clk = 1'b0;
  logic rst;

  uart_word_rx_if #(.WORD_BYTES(WB)) bus ();

  uart_word_rx #(
    .WORD_BYTES     (WB),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0]      q[$];       // bytes waiting in the UART receiver
  logic [8*WB-1:0] exp_q[$];   // words the consumer should see, in order
  int              partial = 0;
  logic [8*WB-1:0] pword = '0;
  int              fire_at = -1;
  int              to_due = -1;
  int              words_seen = 0;
  int              tmo_seen = 0;
  logic [8*WB-1:0] hold_data = '0;
  logic [8*WB-1:0] last_word = '0;
  bit              prev_valid = 1'b0;
  bit              prev_acc = 1'b0;
  bit              prev_rst = 1'b0;
  bit              rdy_rand = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Receiver model: the holding register reloads one clock after an unload strobe.
  initial begin
    bit s;
    bus.rx_empty = 1'b1;
    bus.rx_data  = 8'h00;
    forever begin
      @(negedge clk);
      s = bus.uld_rx_data;
      @(posedge clk);
      #1;
      if (s && q.size() > 0) bus.rx_data = q.pop_front();
      bus.rx_empty = (q.size() == 0);
    end
  end

  // Monitor and reference model: words are formed from the unloaded byte stream.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk("uld_in_reset", bus.uld_rx_data, 0);
      partial = 0; pword = '0; exp_q.delete();
      fire_at = -1; to_due = -1;
      prev_valid = 1'b0; prev_acc = 1'b0; prev_rst = 1'b1;
      continue;
    end
    if (prev_rst) begin
      chk("rst_valid", bus.output_valid, 0);
      chk("rst_data", bus.output_data, 0);
      chk("rst_timeout_err", bus.timeout_err, 0);
      chk("rst_byte_count", bus.byte_count, 0);
      prev_rst = 1'b0;
    end
    if (prev_acc) begin
      chk("valid_after_accept", bus.output_valid, 0);
      chk("count_after_accept", bus.byte_count, 0);
    end
    if (to_due == cyc || bus.timeout_err) begin
      chk("timeout_err", bus.timeout_err, (to_due == cyc));
      if (bus.timeout_err) tmo_seen++;
    end
    if (partial > 0 && cyc == fire_at) begin
      chk("uld_at_timeout", bus.uld_rx_data, 0);
      partial = 0; pword = '0; fire_at = -1; to_due = cyc + 1;
    end
    if (bus.output_valid) begin
      chk("uld_in_hold", bus.uld_rx_data, 0);
      if (!prev_valid) begin
        words_seen++;
        hold_data = bus.output_data;
        last_word = bus.output_data;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word: got %h expected none", bus.output_data);
        end else begin
          chk("word_data", bus.output_data, exp_q.pop_front());
        end
      end else begin
        chk("hold_stable", bus.output_data, hold_data);
      end
    end
    if (bus.uld_rx_data) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_unload: got uld=1 expected 0 with empty receiver");
      end else begin
        pword[8*partial +: 8] = q[0];
        partial++;
        fire_at = cyc + 2 + TMO;
        if (partial == WB) begin
          exp_q.push_back(pword);
          partial = 0; pword = '0; fire_at = -1;
        end
      end
    end
    prev_valid = bus.output_valid;
    prev_acc   = bus.output_valid && bus.output_ready;
  end

  task automatic tick();
    @(posedge clk);
    #2;
    if (rdy_rand) bus.output_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while ((q.size() != 0 || partial != 0 || exp_q.size() != 0 || bus.output_valid) && n < budget) begin
      tick(); n++;
    end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL %s: got no idle expected idle within %0d cycles", nm, budget);
    end
    repeat (3) tick();
  endtask

  task automatic wait_valid(input string nm, input int budget);
    int n = 0;
    while (!bus.output_valid && n < budget) begin
      tick(); n++;
    end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL %s: got no output_valid expected one within %0d cycles", nm, budget);
    end
  endtask

  initial begin
    logic [8*WB-1:0] w;
    logic [7:0]      b;
    int              n, w0, t0;

    rst = 1'b1;
    bus.output_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Ascending bytes with the consumer always ready.
    for (int i = 1; i <= 8; i++) q.push_back(8'(i));
    wait_idle("seq_word", 200);
    chk("seq_word_value", last_word, 64'h0807060504030201);
    chk("seq_byte_count", bus.byte_count, 0);

    // Backpressure: the word is held while the consumer stalls.
    bus.output_ready = 1'b0;
    repeat (8) q.push_back(8'hA5);
    wait_valid("hold_word", 200);
    repeat (50) tick();
    chk("held_valid", bus.output_valid, 1);
    chk("held_data", bus.output_data, 64'hA5A5A5A5A5A5A5A5);
    bus.output_ready = 1'b1;
    tick();
    chk("accept_on_ready", bus.output_valid, 0);
    wait_idle("hold_drain", 100);

    // Partial word abandoned by the inter-byte timeout.
    t0 = tmo_seen;
    for (int i = 0; i < 3; i++) q.push_back(8'hC0 + 8'(i));
    repeat (130) tick();
    chk("timeout_pulses", tmo_seen - t0, 1);
    chk("timeout_byte_count", bus.byte_count, 0);
    for (int i = 0; i < 8; i++) q.push_back(8'h10 + 8'(i));
    wait_idle("after_timeout", 200);
    chk("after_timeout_word", last_word, 64'h1716151413121110);

    // A byte arriving on the very clock the timeout fires starts the next word.
    t0 = tmo_seen;
    for (int i = 0; i < 3; i++) q.push_back(8'h60 + 8'(i));
    n = 0;
    while ((fire_at < 0 || cyc != fire_at - 1) && n < 400) begin tick(); n++; end
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL race_setup: got no timeout window expected one within 400 cycles");
    end
    for (int i = 0; i < 8; i++) q.push_back(8'h70 + 8'(i));
    wait_idle("race_word", 300);
    chk("race_timeout_pulses", tmo_seen - t0, 1);
    chk("race_word_value", last_word, 64'h7776757473727170);

    // Reset in the middle of a word.
    for (int i = 0; i < 5; i++) q.push_back(8'h33);
    repeat (20) tick();
    chk("mid_byte_count", bus.byte_count, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      w[8*i +: 8] = b;
      q.push_back(b);
    end
    wait_idle("post_reset_word", 200);
    chk("post_reset_value", last_word, w);

    // Reset while a word is held: it must never be re-presented.
    bus.output_ready = 1'b0;
    w0 = words_seen;
    repeat (8) q.push_back(8'h5A);
    wait_valid("hold_before_reset", 200);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.output_ready = 1'b1;
    repeat (10) tick();
    chk("hold_reset_words", words_seen - w0, 1);

    // Two words back to back.
    w0 = words_seen;
    for (int i = 0; i < 16; i++) q.push_back(8'(8'h80 + i));
    wait_idle("b2b", 300);
    chk("b2b_words", words_seen - w0, 2);
    chk("b2b_last", last_word, 64'h8F8E8D8C8B8A8988);

    // Random bytes, random gaps straddling the timeout, random backpressure.
    rdy_rand = 1'b1;
    for (int i = 0; i < 150; i++) begin
      q.push_back(8'($urandom));
      if ($urandom_range(0, 19) == 0) repeat ($urandom_range(95, 110)) tick();
      else repeat ($urandom_range(0, 4)) tick();
    end
    rdy_rand = 1'b0;
    bus.output_ready = 1'b1;
    tick();
    wait_idle("random_drain", 3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
